mips_mem_bridge: RTL and testbench

//  Memory-side stage directly downstream of the multicycle MIPS core. Takes the

---
 rtl/mips_mem_bridge.sv | 124 ++++++++++++
 tb/tb_mips_mem_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_bridge.sv
`default_nettype none
// mips_mem_bridge: serialises MIPS fetch/load/store requests onto one req/ack memory port.
// Optional wait-cycle statistics counter enabled by defining MIPS_MEM_BRIDGE_STAT_EN.
module mips_mem_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        IRWrite,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  output logic [31:0] Instruction,
  output logic [31:0] Read_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic [31:0] wait_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {K_LOAD = 2'd0, K_FETCH = 2'd1, K_STORE = 2'd2} kind_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state, next_state;
  kind_t       kind, req_kind;
  logic [15:0] timer, timer_inc;
  logic        has_req, timed_out, stall_c;
  logic [31:0] req_addr;

  assign has_req   = MemWrite | IRWrite | MemRead;
  assign req_kind  = MemWrite ? K_STORE : (IRWrite ? K_FETCH : K_LOAD);
  // Byte offset is dropped without any misalignment check.
  assign req_addr  = (req_kind == K_FETCH ? PC : Address) & ~32'h3;
  assign timer_inc = (timer == 16'hFFFF) ? timer : 16'(timer + 16'd1);
  assign timed_out = (timer_inc == TIMEOUT_W);

  assign mem_req = (state == S_WAIT);
  assign mem_we  = mem_req && (kind == K_STORE);
  assign stall   = rst & stall_c;

  always_comb begin
    next_state = state;
    stall_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (has_req) begin
          stall_c    = 1'b1;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (mem_ack || timed_out) next_state = S_RESP;
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      kind        <= K_LOAD;
      timer       <= 16'd0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      Instruction <= 32'd0;
      Read_data   <= 32'd0;
      err         <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          timer <= 16'd0;
          if (has_req) begin
            kind      <= req_kind;
            mem_addr  <= req_addr;
            mem_wdata <= Write_data;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            timer <= 16'd0;
            if (kind == K_FETCH) Instruction <= mem_rdata;
            if (kind == K_LOAD)  Read_data   <= mem_rdata;
          end else if (timed_out) begin
            timer <= 16'd0;
            err   <= 1'b1;
            if (kind == K_FETCH) Instruction <= ERR_DATA;
            if (kind == K_LOAD)  Read_data   <= ERR_DATA;
          end else begin
            timer <= timer_inc;
          end
        end
        default: timer <= 16'd0;
      endcase
    end
  end

`ifdef MIPS_MEM_BRIDGE_STAT_EN
  logic [31:0] wait_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       wait_cnt_q <= 32'd0;
    else if (stall) wait_cnt_q <= wait_cnt_q + 32'd1;
  end

  assign wait_cnt = wait_cnt_q;
`else
  assign wait_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_bridge.sv
`default_nettype none
// tb_mips_mem_bridge: table-driven access vectors plus priority, late-ack and reset sequences.
module tb_mips_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0, Address = '0, Write_data = '0, mem_rdata = '0;
  logic        IRWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, mem_ack = 1'b0;
  logic [31:0] Instruction, Read_data, mem_addr, mem_wdata, wait_cnt;
  logic        stall, mem_req, mem_we, err;

  int checks = 0;
  int errors = 0;
  int stall_total = 0;

  always #5 clk = ~clk;

  mips_mem_bridge #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst), .PC(PC), .IRWrite(IRWrite), .Address(Address),
    .MemRead(MemRead), .MemWrite(MemWrite), .Write_data(Write_data),
    .Instruction(Instruction), .Read_data(Read_data), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .wait_cnt(wait_cnt)
  );

  typedef struct {
    logic        irw, mrd, mwr;
    logic [31:0] pc, addr, wdata, rdata;
    int          ack_at;        // WAIT cycle carrying the ack; 0 = never ack
    int          exp_stalls, exp_waits;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_instr, exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wait_cnt();
`ifdef MIPS_MEM_BRIDGE_STAT_EN
    return 32'(stall_total);
`else
    return 32'd0;
`endif
  endfunction

  // Applies one request and tracks it until the RESP cycle (stall low after stalling).
  task automatic run_access(input vec_t v, output int stalls, output int waits,
                            output logic [31:0] a, output logic we,
                            output logic [31:0] wd, output bit done);
    @(negedge clk);
    IRWrite = v.irw; MemRead = v.mrd; MemWrite = v.mwr;
    PC = v.pc; Address = v.addr; Write_data = v.wdata; mem_rdata = v.rdata;
    mem_ack = 1'b0;
    stalls = 0; waits = 0; a = '0; we = 1'b0; wd = '0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) stalls++;
      if (!stall && stalls > 0) begin
        done = 1'b1;
      end else begin
        if (mem_req) begin
          waits++; a = mem_addr; we = mem_we; wd = mem_wdata;
        end
        mem_ack = mem_req && (v.ack_at != 0) && (waits == v.ack_at);
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    stall_total += stalls;
  endtask

  task automatic clear_req();
    IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  function automatic vec_t mk(logic irw, logic mrd, logic mwr, logic [31:0] pc,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              int ack_at, int es, int ew, logic [31:0] ea, logic ewe,
                              logic [31:0] ei, logic [31:0] er, logic ee);
    vec_t v;
    v.irw = irw; v.mrd = mrd; v.mwr = mwr; v.pc = pc; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.ack_at = ack_at;
    v.exp_stalls = es; v.exp_waits = ew; v.exp_addr = ea; v.exp_we = ewe;
    v.exp_instr = ei; v.exp_rd = er; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    int          s, w;
    logic [31:0] a, wd;
    logic        we;
    bit          done;
    vec_t        v;

    vecs[0] = mk(1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h2409_0005, 1, 2, 1,
                 32'h40, 0, 32'h2409_0005, 32'h0, 0);
    vecs[1] = mk(0, 0, 1, 32'h0, 32'h103, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 3, 4, 3,
                 32'h100, 1, 32'h2409_0005, 32'h0, 0);
    vecs[2] = mk(0, 1, 0, 32'h0, 32'h208, 32'h0, 32'h1234_5678, 2, 3, 2,
                 32'h208, 0, 32'h2409_0005, 32'h1234_5678, 0);
    vecs[3] = mk(1, 1, 0, 32'h44, 32'h999, 32'h0, 32'h8C88_0004, 1, 2, 1,
                 32'h44, 0, 32'h8C88_0004, 32'h1234_5678, 0);
    vecs[4] = mk(0, 1, 0, 32'h0, 32'h300, 32'h0, 32'h5555_5555, 0, 5, 4,
                 32'h300, 0, 32'h8C88_0004, 32'hDEAD_BEEF, 1);
    vecs[5] = mk(1, 0, 0, 32'h7FFF_FFFE, 32'h0, 32'h0, 32'h3C01_1001, 1, 2, 1,
                 32'h7FFF_FFFC, 0, 32'h3C01_1001, 32'hDEAD_BEEF, 1);

    // Reset state, with a request already asserted to prove stall is held low.
    IRWrite = 1'b1; PC = 32'h80;
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_instr", Instruction, 32'd0);
    check("reset_rdata", Read_data, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_wait_cnt", wait_cnt, 32'd0);
    clear_req();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_access(vecs[i], s, w, a, we, wd, done);
      clear_req();
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_stalls", i), 32'(s), 32'(vecs[i].exp_stalls));
      check($sformatf("v%0d_waits", i), 32'(w), 32'(vecs[i].exp_waits));
      check($sformatf("v%0d_addr", i), a, vecs[i].exp_addr);
      check($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) check($sformatf("v%0d_wdata", i), wd, vecs[i].wdata);
      check($sformatf("v%0d_instr", i), Instruction, vecs[i].exp_instr);
      check($sformatf("v%0d_rdata", i), Read_data, vecs[i].exp_rd);
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_wait_cnt", i), wait_cnt, exp_wait_cnt());
    end

    // Acks with no outstanding request must not touch any result register.
    @(negedge clk);
    mem_rdata = 32'h1111_1111; mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("spurious_ack_req", {31'd0, mem_req}, 32'd0);
      check("spurious_ack_stall", {31'd0, stall}, 32'd0);
    end
    mem_ack = 1'b0;
    check("spurious_ack_rdata", Read_data, 32'hDEAD_BEEF);
    check("spurious_ack_instr", Instruction, 32'h3C01_1001);

    // Store and fetch together: store first, the held fetch only after RESP.
    v = mk(1, 0, 1, 32'h60, 32'h500, 32'h0BAD_F00D, 32'h0, 1, 2, 1,
           32'h500, 1, 32'h0, 32'h0, 1);
    run_access(v, s, w, a, we, wd, done);
    check("prio_store_done", {31'd0, done}, 32'd1);
    check("prio_store_stalls", 32'(s), 32'd2);
    check("prio_store_addr", a, 32'h500);
    check("prio_store_we", {31'd0, we}, 32'd1);
    check("prio_store_wdata", wd, 32'h0BAD_F00D);
    check("prio_store_instr", Instruction, 32'h3C01_1001);
    v = mk(1, 0, 0, 32'h60, 32'h500, 32'h0, 32'hCAFE_BABE, 1, 2, 1,
           32'h60, 0, 32'h0, 32'h0, 1);
    run_access(v, s, w, a, we, wd, done);
    clear_req();
    check("prio_fetch_stalls", 32'(s), 32'd2);
    check("prio_fetch_addr", a, 32'h60);
    check("prio_fetch_we", {31'd0, we}, 32'd0);
    check("prio_fetch_instr", Instruction, 32'hCAFE_BABE);
    check("prio_wait_cnt", wait_cnt, exp_wait_cnt());

    // Asynchronous reset in the middle of a WAIT state.
    @(negedge clk);
    IRWrite = 1'b1; PC = 32'h88;
    @(negedge clk); #1;
    check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_reset_stall", {31'd0, stall}, 32'd0);
    check("mid_reset_mem_addr", mem_addr, 32'd0);
    check("mid_reset_instr", Instruction, 32'd0);
    check("mid_reset_rdata", Read_data, 32'd0);
    check("mid_reset_err", {31'd0, err}, 32'd0);
    check("mid_reset_wait_cnt", wait_cnt, 32'd0);
    stall_total = 0;
    clear_req();
    @(negedge clk);
    rst = 1'b1;
    v = mk(1, 0, 0, 32'h8C, 32'h0, 32'h0, 32'h2008_0001, 2, 3, 2,
           32'h8C, 0, 32'h0, 32'h0, 0);
    run_access(v, s, w, a, we, wd, done);
    clear_req();
    check("post_reset_done", {31'd0, done}, 32'd1);
    check("post_reset_stalls", 32'(s), 32'd3);
    check("post_reset_addr", a, 32'h8C);
    check("post_reset_instr", Instruction, 32'h2008_0001);
    check("post_reset_err", {31'd0, err}, 32'd0);
    check("post_reset_wait_cnt", wait_cnt, exp_wait_cnt());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
